// File: rtl/arb_mux_rr.sv
// Registered CH-channel arbitrating mux: round-robin (MODE 0) or fixed lowest-index priority (MODE 1).
// Latency: a request granted at edge k appears on out_data/out_sel/out_valid right after edge k.
// Backpressure: out_valid & ~out_ready stalls; no grants and all registers hold until drained.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   req[CH]              per-channel request (channel i has valid data on din[i*n +: n])
//   din[CH*n]            flattened channel data
//   gnt[CH]              combinational one-hot accept; channel i is captured at this edge
//   out_valid/out_ready  registered output handshake
//   out_data[n]          registered winning data
//   out_sel[SW]          registered index of the channel that supplied out_data
module arb_mux_rr #(
  parameter  int n    = 32,
  parameter  int CH   = 4,
  parameter  int MODE = 0,
  localparam int SW   = $clog2(CH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [CH-1:0]   req,
  input  logic [CH*n-1:0] din,
  output logic [CH-1:0]   gnt,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [n-1:0]    out_data,
  output logic [SW-1:0]   out_sel
);

  // Round-robin search start; always in 0..CH-1, stays 0 in fixed-priority mode.
  logic [SW-1:0] ptr;

  logic          load;
  logic          win_any;
  logic [SW-1:0] win_idx;
  logic [CH-1:0] win_oh;
  logic [n-1:0]  win_data;
  logic [SW-1:0] ptr_nxt;

  // The output register can accept new data when empty or draining this cycle.
  assign load = ~out_valid | out_ready;

  // Winner search. The loop runs from the farthest candidate to the nearest so
  // the last match written is the one closest to the search start. The candidate
  // index carries one spare bit so ptr+k can be wrapped for non-power-of-two CH.
  always_comb begin
    logic [SW:0] cand;
    win_any = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = CH - 1; k >= 0; k--) begin
      if (MODE == 1) begin
        cand = (SW+1)'(k);
      end else begin
        cand = {1'b0, ptr} + (SW+1)'(k);
        if (cand >= (SW+1)'(CH)) begin
          cand = cand - (SW+1)'(CH);
        end
      end
      if (req[cand[SW-1:0]]) begin
        win_any = 1'b1;
        win_idx = cand[SW-1:0];
      end
    end
  end

  always_comb begin
    win_oh          = '0;
    win_oh[win_idx] = win_any;
  end

  // Grant is masked while reset is held so no requester sees an accept that the
  // registers will not honour.
  assign gnt = (rst_n & load) ? win_oh : '0;

  assign win_data = din[win_idx*n +: n];

  // Next search start is one past the winner, wrapping CH-1 back to 0.
  assign ptr_nxt = (win_idx == SW'(CH - 1)) ? '0 : win_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (win_any) begin
        out_valid <= 1'b1;
        out_data  <= win_data;
        out_sel   <= win_idx;
        if (MODE == 0) begin
          ptr <= ptr_nxt;
        end
      end else begin
        // Nothing to refill with: mark empty but keep the last data and index.
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/arb_mux_rr.md
# arb_mux_rr

Registered, parametrised N-channel arbitrating multiplexer with a valid/ready output handshake. Selects one of `CH` requesting channels each cycle, in round-robin or fixed-priority order, and registers the winner's data and index for downstream logic. Sits where several sources share one datapath port, for example instruction fetch and load/store sharing the single-ported memory or writeback sources sharing the register-file write port.

## Interface

Parameters:
- `n`, default 32: data width per channel.
- `CH`, default 4: channel count; legal range 2..16, any value including non-powers of two.
- `MODE`, default 0: arbitration mode; 0 = round-robin, 1 = fixed priority, lowest index wins.
- `SW` is derived, not overridable: `$clog2(CH)`.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req` input CH: per-channel request; bit i asserted means channel i presents valid data.
- `din` input CH*n: flattened channel data; channel i occupies bits `[i*n +: n]`.
- `gnt` output CH: combinational one-hot accept; bit i high means channel i's data is captured at this edge.
- `out_valid` output 1: registered; the output holds data.
- `out_ready` input 1: downstream accepts `out_data` when both `out_valid` and `out_ready` are high.
- `out_data` output n: registered winning data.
- `out_sel` output SW: registered index of the channel that supplied `out_data`.

## Operation

- `load = ~out_valid | out_ready`: the output register is empty or is being drained this cycle.
- Winner selection is combinational over `req`:
  - MODE 0: the first asserted bit found searching upward from pointer `ptr`, wrapping `CH-1` to 0.
  - MODE 1: the lowest asserted index; `ptr` is ignored.
- `gnt` equals `load` AND the one-hot winner. `gnt` is all-zero when `load` is 0 or `req` is 0.
- On an edge with any `gnt` bit set:
  - `out_data` takes the winner's `din` slice.
  - `out_sel` takes the winner index.
  - `out_valid` goes to 1.
  - In MODE 0, `ptr` takes winner+1, with winner `CH-1` wrapping to 0.
- On an edge with `load` = 1 and no request: `out_valid` goes to 0. `out_data`, `out_sel` and `ptr` hold.
- On an edge with `load` = 0 (stall): all registers hold and no channel is granted.
- Requester contract: hold `req` and `din` stable until the cycle in which its `gnt` bit is high. Deasserting `req` before grant is legal; the request is simply dropped.
- Starvation bound in MODE 0: a continuously requesting channel is granted within `CH` loads. MODE 1 has no fairness guarantee.
- `out_data` and `out_sel` must not change while `out_valid=1` and `out_ready=0`.

## Timing

- Reset (asynchronous assert, synchronous-to-clk deassert is the integrator's responsibility):
  - `out_valid`=0, `out_data`=0, `out_sel`=0, `ptr`=0.
  - `gnt`=0, because `load`=1 but the grant is masked while `rst_n`=0.
- Latency: `req` seen at edge k with `load`=1 gives `out_valid`=1 with that channel's data after edge k.
- Throughput: one transfer per cycle while `out_ready` stays high.
- Simultaneous drain and refill: when `out_valid`=1, `out_ready`=1 and a request is pending, the new data replaces the old at the same edge, with no bubble.
- Reset mid-transfer: the pending output is discarded and arbitration restarts from channel 0. No `gnt` is issued during reset.
- `gnt` is a combinational function of `req`, `ptr`, `out_valid` and `out_ready`. There is no path from `din` to `gnt`.

## Test plan

- **Reset:** assert `rst_n`=0 mid-stream with `out_valid`=1 → `out_valid`=0, `out_data`=0, `out_sel`=0 immediately without a clock edge. After release, `req`=4'b1000 is granted first from `ptr`=0.
- **Round-robin fairness:** MODE 0, CH=4, `req`=4'b1111 held, `out_ready`=1, `din` slice i = 0xA0+i → `out_sel` sequence 0,1,2,3,0,1. `out_data` sequence 0xA0,0xA1,0xA2,0xA3,0xA0. Exactly one `gnt` bit per cycle.
- **Backpressure:** load channel 2 (0xA2), then `out_ready`=0 for 3 cycles with `req`=4'b1111 → `gnt`=0 and `out_data`=0xA2 stable for all 3 cycles. When `out_ready` returns to 1, the next grant is channel 3 in the same cycle, with no bubble.
- **Fixed priority:** MODE 1, `req`=4'b1010 held for 4 cycles → `out_sel`=1 every cycle and channel 3 is never granted. When `req` changes to 4'b1000, the grant moves to channel 3 on the next load.
- **Non-power-of-two wrap:** CH=3, `req`=3'b111 → `out_sel` sequence 0,1,2,0. `ptr` never holds 3.
- **Idle drain:** `out_valid`=1, `out_ready`=1, `req`=0 → `out_valid`=0 after the edge and `out_data` retains its last value. A single `req[1]` pulse after that gives `out_valid`=1 one cycle later with `out_sel`=1.
